// File: rtl/tt_um_saubaanh_counter_host_pkg.sv
// Shared definitions for the counter-host tile: opcodes, FSM states and pin indices.
package tt_um_saubaanh_counter_host_pkg;

  localparam int unsigned BUS_W = 8;

  // Command opcodes carried on ui_in[2:1]
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STEP  = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } opcode_t;

  // Sequencer states, 3-bit binary encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STEP    = 3'd2,
    RD_TURN = 3'd3,
    RD_CAP  = 3'd4,
    DONE    = 3'd5
  } state_t;

  // ui_in bit positions
  localparam int unsigned UI_CMD_VALID = 0;
  localparam int unsigned UI_OP_LSB    = 1;
  localparam int unsigned UI_OP_MSB    = 2;
  localparam int unsigned UI_SHOW      = 7;

  // uo_out bit positions; load/count_en/drive_en match the counter tile
  localparam int unsigned UO_LOAD         = 0;
  localparam int unsigned UO_COUNT_EN     = 1;
  localparam int unsigned UO_BUSY         = 2;
  localparam int unsigned UO_DRIVE_EN     = 3;
  localparam int unsigned UO_DONE         = 4;
  localparam int unsigned UO_RESULT_VALID = 5;

endpackage

// File: rtl/tt_um_saubaanh_counter_host_step_timer.sv
// Loadable 8-bit down-counter timing the STEP pulse train.
module saubaanh_step_timer
  import tt_um_saubaanh_counter_host_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BUS_W-1:0] load_value,
  input  logic             dec,
  output logic [BUS_W-1:0] count,
  output logic             zero
);

  // Load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tt_um_saubaanh_counter_host.sv
// Host-side sequencer driving an 8-bit programmable counter tile over a shared bus.
module tt_um_saubaanh_counter_host
  import tt_um_saubaanh_counter_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t     state;
  state_t     state_nx;
  logic [7:0] operand;
  logic [7:0] result;
  logic       result_valid;
  logic       prev_cv;
  logic       armed;
  logic       show_r;
  logic       accept;
  opcode_t    op_in;
  logic       cmd_valid;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;
  logic [7:0] tmr_value;
  logic       unused_ok;

  assign cmd_valid = ui_in[UI_CMD_VALID];
  assign op_in     = opcode_t'(ui_in[UI_OP_MSB:UI_OP_LSB]);
  assign unused_ok = &{1'b0, ui_in[6:3]};

  // A command needs a fresh rising edge; 'armed' stops a cmd_valid held
  // high through reset release from counting as an edge against prev_cv=0.
  assign accept = (state == IDLE) && ena && cmd_valid && !prev_cv && armed;

  // The timer holds N-1 so the last STEP cycle coincides with zero.
  assign tmr_load  = accept && (op_in == OP_STEP) && (uio_in != '0);
  assign tmr_value = uio_in - 8'd1;
  assign tmr_dec   = ena && (state == STEP);

  saubaanh_step_timer u_step_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .dec        (tmr_dec),
    .count      (),
    .zero       (tmr_zero)
  );

  // Input samplers: edge detect, arming and show_result run regardless of ena
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_cv <= 1'b0;
      armed   <= 1'b0;
      show_r  <= 1'b0;
    end else begin
      prev_cv <= cmd_valid;
      show_r  <= ui_in[UI_SHOW];
      if (!cmd_valid) armed <= 1'b1;
    end
  end

  // State, operand and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      operand      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        operand      <= (op_in == OP_CLEAR) ? '0 : uio_in;
        result_valid <= 1'b0;
      end else if (ena && (state == RD_CAP)) begin
        result       <= uio_in;
        result_valid <= 1'b1;
      end
    end
  end

  // Next-state logic; every transition is frozen while ena=0
  always_comb begin
    state_nx = state;
    if (ena) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (op_in)
              OP_LOAD, OP_CLEAR: state_nx = LOAD;
              OP_STEP:           state_nx = (uio_in == '0) ? DONE : STEP;
              OP_READ:           state_nx = RD_TURN;
              default:           state_nx = IDLE;
            endcase
          end
        end
        LOAD:    state_nx = DONE;
        STEP:    if (tmr_zero) state_nx = DONE;
        RD_TURN: state_nx = RD_CAP;
        RD_CAP:  state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output decode from registered state only; ena gates control lines and bus drive
  always_comb begin
    uo_out  = '0;
    uio_out = '0;
    uio_oe  = '0;
    uo_out[UO_BUSY]         = (state != IDLE);
    uo_out[UO_DONE]         = (state == DONE);
    uo_out[UO_RESULT_VALID] = result_valid;
    if (ena) begin
      uo_out[UO_LOAD]     = (state == LOAD);
      uo_out[UO_COUNT_EN] = (state == STEP);
      uo_out[UO_DRIVE_EN] = (state == RD_TURN) || (state == RD_CAP);
      if (state == LOAD) begin
        uio_oe  = '1;
        uio_out = operand;
      end else if ((state == IDLE) && show_r && result_valid) begin
        uio_oe  = '1;
        uio_out = result;
      end
    end
  end

endmodule
